// File: rtl/qoi_dma_ctrl_if.sv
// rtl/qoi_dma_ctrl_if.sv - CPU register port and DMA bus-master signals of the QOI copy engine
interface qoi_dma_ctrl_if;
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        cpu_we;
    logic        rdy;
    logic        irq;
    logic        bus_sel;
    logic [15:0] m_addr;
    logic        m_we;
    logic [7:0]  m_do;
    logic [7:0]  m_di;

    modport master (
        input  cs, we, addr, data_i, cpu_we, m_di,
        output data_o, rdy, irq, bus_sel, m_addr, m_we, m_do
    );

    modport slave (
        output cs, we, addr, data_i, cpu_we, m_di,
        input  data_o, rdy, irq, bus_sel, m_addr, m_we, m_do
    );
endinterface

// File: rtl/qoi_dma_ctrl.sv
// rtl/qoi_dma_ctrl.sv - byte-copy DMA engine and CPU/DMA bus arbiter with periodic bus yield
module qoi_dma_ctrl #(
    parameter int BURST = 16,
    parameter int GAP   = 2
) (
    input  logic           clk,
    input  logic           rst,
    qoi_dma_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_WR, S_YIELD, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] src, dst, len;
    logic        src_inc, dst_inc, irq_en;
    logic        busy, done, aborted, abort_pend;
    logic [7:0]  bcnt, gcnt;
    logic [7:0]  data_q;
    logic        to_abort;

    logic reg_wr, ctrl_wr, start_req, abort_req, abort_go, status_rd;

    assign reg_wr    = bus.cs & bus.we;
    assign ctrl_wr   = reg_wr & (bus.addr == 3'd6);
    assign start_req = ctrl_wr & bus.data_i[0];
    assign abort_req = ctrl_wr & bus.data_i[7] & busy;
    assign abort_go  = abort_pend | abort_req;
    assign status_rd = bus.cs & ~bus.we & (bus.addr == 3'd7);
    assign bus.irq   = done & irq_en;

    always_comb begin
        state_nx    = state;
        to_abort    = 1'b0;
        bus.rdy     = 1'b1;
        bus.bus_sel = 1'b0;
        bus.m_addr  = 16'h0000;
        bus.m_we    = 1'b0;
        bus.m_do    = data_q;
        case (state)
            S_IDLE: begin
                if (start_req)
                    state_nx = (len == 16'h0000) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                bus.rdy = 1'b0;
                if (abort_go) begin
                    state_nx = S_DONE;
                    to_abort = 1'b1;
                end else if (!bus.cpu_we) begin
                    // wait out any CPU write already on the bus before taking it over
                    state_nx = S_RD;
                end
            end
            S_RD: begin
                bus.rdy     = 1'b0;
                bus.bus_sel = 1'b1;
                bus.m_addr  = src;
                state_nx    = S_WR;
            end
            S_WR: begin
                bus.rdy     = 1'b0;
                bus.bus_sel = 1'b1;
                bus.m_addr  = dst;
                bus.m_we    = 1'b1;
                bus.m_do    = bus.m_di;
                if (len == 16'h0001) begin
                    state_nx = S_DONE;
                end else if (abort_go) begin
                    state_nx = S_DONE;
                    to_abort = 1'b1;
                end else if ((bcnt + 8'd1) == 8'(BURST)) begin
                    state_nx = S_YIELD;
                end else begin
                    state_nx = S_RD;
                end
            end
            S_YIELD: begin
                if (abort_go) begin
                    state_nx = S_DONE;
                    to_abort = 1'b1;
                end else if (gcnt == 8'(GAP - 1)) begin
                    state_nx = S_REQ;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            src        <= 16'h0000;
            dst        <= 16'h0000;
            len        <= 16'h0000;
            src_inc    <= 1'b0;
            dst_inc    <= 1'b0;
            irq_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            bcnt       <= 8'h00;
            gcnt       <= 8'h00;
            data_q     <= 8'h00;
        end else begin
            state <= state_nx;

            if (reg_wr && !busy) begin
                case (bus.addr)
                    3'd0: src[7:0]  <= bus.data_i;
                    3'd1: src[15:8] <= bus.data_i;
                    3'd2: dst[7:0]  <= bus.data_i;
                    3'd3: dst[15:8] <= bus.data_i;
                    3'd4: len[7:0]  <= bus.data_i;
                    3'd5: len[15:8] <= bus.data_i;
                    3'd6: begin
                        src_inc <= bus.data_i[1];
                        dst_inc <= bus.data_i[2];
                        irq_en  <= bus.data_i[3];
                    end
                    default: ;
                endcase
            end

            if (state == S_IDLE && start_req && len != 16'h0000) begin
                busy <= 1'b1;
                bcnt <= 8'h00;
            end

            if (abort_req)
                abort_pend <= 1'b1;
            if (state == S_IDLE || state_nx == S_DONE)
                abort_pend <= 1'b0;

            if (state == S_WR) begin
                data_q <= bus.m_di;
                src    <= src + {15'd0, src_inc};
                dst    <= dst + {15'd0, dst_inc};
                len    <= len - 16'd1;
                bcnt   <= bcnt + 8'd1;
            end

            if (state == S_YIELD) begin
                bcnt <= 8'h00;
                gcnt <= gcnt + 8'd1;
            end else begin
                gcnt <= 8'h00;
            end

            if (status_rd) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            // completion flags are raised on entry so STATUS shows done during the DONE cycle
            if (state_nx == S_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
                if (to_abort)
                    aborted <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.data_o = 8'h00;
        case (bus.addr)
            3'd0: bus.data_o = src[7:0];
            3'd1: bus.data_o = src[15:8];
            3'd2: bus.data_o = dst[7:0];
            3'd3: bus.data_o = dst[15:8];
            3'd4: bus.data_o = len[7:0];
            3'd5: bus.data_o = len[15:8];
            3'd6: bus.data_o = {4'b0000, irq_en, dst_inc, src_inc, 1'b0};
            3'd7: bus.data_o = {5'b00000, aborted, done, busy};
            default: bus.data_o = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_qoi_dma_ctrl.sv
// tb/tb_qoi_dma_ctrl.sv - directed scoreboard bench for qoi_dma_ctrl
module tb_qoi_dma_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qoi_dma_ctrl_if bus();
    qoi_dma_ctrl #(.BURST(16), .GAP(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
    } cyc_t;

    int         checks = 0;
    int         errors = 0;
    cyc_t       sb[$];
    logic [1:0] trace[$];
    logic [1:0] exp_tr[$];
    bit         mon_en = 1'b1;
    bit         tr_en  = 1'b0;
    logic [7:0] wmem [0:65535];
    logic [7:0] m_di_r = 8'h00;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return {a[3:0], a[7:4]} ^ 8'h5A ^ a[15:8];
    endfunction

    // source memory is a fixed pattern; writes land in wmem
    assign bus.m_di = m_di_r;
    always @(posedge clk) begin
        if (bus.bus_sel && bus.m_we)
            wmem[bus.m_addr] <= bus.m_do;
        m_di_r <= pat(bus.m_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (tr_en)
            trace.push_back({bus.rdy, bus.bus_sel});
        if (!rst && mon_en && bus.bus_sel) begin
            chk("bus_cycle_expected", (sb.size() != 0), 1);
            chk("rdy_low_on_bus", bus.rdy, 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bus_addr_we", {bus.m_addr, bus.m_we}, {e.a, e.w});
                if (e.w)
                    chk("bus_wdata", bus.m_do, e.d);
            end
        end
    end

    task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                             input bit si, input bit di);
        for (int i = 0; i < n; i++) begin
            sb.push_back({s, 1'b0, 8'h00});
            sb.push_back({d, 1'b1, pat(s)});
            s = s + {15'd0, si};
            d = d + {15'd0, di};
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        v = bus.data_o;
        @(posedge clk); #1;
        bus.cs = 1'b0;
    endtask

    task automatic rd16(input logic [2:0] a, output logic [15:0] v);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a + 3'd1, hi);
        v = {hi, lo};
    endtask

    task automatic set_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        wr(3'd0, s[7:0]); wr(3'd1, s[15:8]);
        wr(3'd2, d[7:0]); wr(3'd3, d[15:8]);
        wr(3'd4, l[7:0]); wr(3'd5, l[15:8]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bus.addr = 3'd7;
        while (n < 2000) begin
            @(negedge clk);
            if (bus.data_o[1]) break;
            n++;
        end
        chk({tag, "_done_timeout"}, (n < 2000), 1);
        @(posedge clk); #1;
        tr_en = 1'b0;
    endtask

    task automatic add_tr(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) exp_tr.push_back(v);
    endtask

    task automatic cmp_trace(input string tag);
        int bad = -1;
        chk({tag, "_trace_len"}, trace.size(), exp_tr.size());
        for (int i = 0; i < trace.size() && i < exp_tr.size(); i++)
            if (trace[i] !== exp_tr[i] && bad < 0) bad = i;
        chk({tag, "_trace_first_diff"}, bad, -1);
        trace.delete();
        exp_tr.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] v16;
        int          n;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 3'd0; bus.data_i = 8'h00; bus.cpu_we = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", bus.rdy, 1);
        chk("rst_bus_sel", bus.bus_sel, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_addr", bus.m_addr, 16'h0000);
        chk("rst_m_do", bus.m_do, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk("rst_reg_read", {a[7:0], v}, {a[7:0], 8'h00});
        end

        // T1: 4-byte incrementing copy with irq
        set_regs(16'h9000, 16'h8000, 16'd4);
        push_xfer(16'h9000, 16'h8000, 4, 1'b1, 1'b1);
        wr(3'd6, 8'h0F);
        wait_done("t1");
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_irq", bus.irq, 1);
        for (int i = 0; i < 4; i++)
            chk("t1_img", wmem[16'h8000 + 16'(i)], pat(16'h9000 + 16'(i)));
        rd16(3'd4, v16); chk("t1_len", v16, 16'h0000);
        rd16(3'd0, v16); chk("t1_src", v16, 16'h9004);
        rd16(3'd2, v16); chk("t1_dst", v16, 16'h8004);
        rd(3'd7, v); chk("t1_status", v, 8'h02);
        chk("t1_irq_cleared", bus.irq, 0);
        rd(3'd7, v); chk("t1_status_cleared", v, 8'h00);

        // T2: fixed destination window
        set_regs(16'h9010, 16'hA400, 16'd3);
        push_xfer(16'h9010, 16'hA400, 3, 1'b1, 1'b0);
        wr(3'd6, 8'h03);
        wait_done("t2");
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_irq", bus.irq, 0);
        chk("t2_last_byte", wmem[16'hA400], pat(16'h9012));
        rd16(3'd0, v16); chk("t2_src", v16, 16'h9013);
        rd16(3'd2, v16); chk("t2_dst", v16, 16'hA400);
        rd(3'd7, v); chk("t2_status", v, 8'h02);

        // T3: burst of 16, 2-cycle yield, re-request, 4 more
        set_regs(16'h9080, 16'h8200, 16'd20);
        push_xfer(16'h9080, 16'h8200, 20, 1'b1, 1'b1);
        wr(3'd6, 8'h07);
        tr_en = 1'b1;
        wait_done("t3");
        chk("t3_sb_empty", sb.size(), 0);
        add_tr(2'b00, 1); add_tr(2'b01, 32); add_tr(2'b10, 2);
        add_tr(2'b00, 1); add_tr(2'b01, 8); add_tr(2'b10, 1);
        cmp_trace("t3");
        rd(3'd7, v); chk("t3_status", v, 8'h02);

        // T4: CPU write in flight holds REQ
        set_regs(16'h9020, 16'h8040, 16'd2);
        push_xfer(16'h9020, 16'h8040, 2, 1'b1, 1'b1);
        wr(3'd6, 8'h07);
        tr_en = 1'b1;
        bus.cpu_we = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_we = 1'b0;
        wait_done("t4");
        chk("t4_sb_empty", sb.size(), 0);
        add_tr(2'b00, 3); add_tr(2'b01, 4); add_tr(2'b10, 1);
        cmp_trace("t4");
        rd(3'd7, v); chk("t4_status", v, 8'h02);

        // T5: zero length completes without a bus cycle
        set_regs(16'h9000, 16'h8000, 16'd0);
        wr(3'd6, 8'h01);
        bus.addr = 3'd7;
        @(negedge clk);
        chk("t5_done_next_cycle", bus.data_o, 8'h02);
        chk("t5_no_bus", bus.bus_sel, 0);
        wait_done("t5");
        chk("t5_irq", bus.irq, 0);
        rd(3'd7, v); chk("t5_status", v, 8'h02);

        // T6: abort during first yield
        set_regs(16'h9040, 16'h8100, 16'd40);
        push_xfer(16'h9040, 16'h8100, 16, 1'b1, 1'b1);
        wr(3'd6, 8'h07);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.rdy && !bus.bus_sel) break;
            n++;
        end
        chk("t6_yield_timeout", (n < 200), 1);
        wr(3'd6, 8'h80);
        wait_done("t6");
        chk("t6_sb_empty", sb.size(), 0);
        rd(3'd7, v); chk("t6_status", v, 8'h06);
        rd16(3'd4, v16); chk("t6_len", v16, 16'd24);
        rd16(3'd0, v16); chk("t6_src", v16, 16'h9050);
        rd16(3'd2, v16); chk("t6_dst", v16, 16'h8110);

        // T7: reset mid-burst
        mon_en = 1'b0;
        set_regs(16'h9000, 16'h8300, 16'd10);
        wr(3'd6, 8'h07);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.bus_sel) break;
            n++;
        end
        chk("t7_bus_timeout", (n < 50), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t7_bus_sel", bus.bus_sel, 0);
        chk("t7_rdy", bus.rdy, 1);
        chk("t7_m_we", bus.m_we, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rd(3'd7, v); chk("t7_status", v, 8'h00);
        rd(3'd4, v); chk("t7_len", v, 8'h00);
        mon_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
